// File: rtl/run_length_detector.sv
// -----------------------------------------------------------------------------
// run_length_detector
//
// Flags a run of RUN_LEN consecutive identical bits on a serial input stream.
// This is the parametrised successor to the fixed three-ones/three-zeros
// detector. It typically sits behind a deserialiser or line monitor and reports
// stuck-at or long-run conditions to control logic.
//
// Parameters
//   RUN_LEN  run length that triggers detection (>= 2)
//   EVT_W    width of the saturating detection-event counter
//   CW       derived width of run_cnt (local, not overridable)
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   en       in   sample qualifier; x is consumed only when en=1
//   x        in   serial data bit
//   mode     in   00 both polarities, 01 ones only, 10 zeros only, 11 disabled
//   overlap  in   1: detection holds while the run continues
//                 0: the run restarts after each detection
//   clr_cnt  in   synchronous clear of evt_cnt
//   y        out  y_ones | y_zeros
//   y_ones   out  run of RUN_LEN ones present and enabled by mode
//   y_zeros  out  run of RUN_LEN zeros present and enabled by mode
//   run_cnt  out  length of the current run, saturating at RUN_LEN
//   evt_cnt  out  number of detection events, saturating at all-ones
// -----------------------------------------------------------------------------
module run_length_detector #(
  parameter  int RUN_LEN = 3,
  parameter  int EVT_W   = 8,
  localparam int CW      = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic [1:0]       mode,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             y,
  output logic             y_ones,
  output logic             y_zeros,
  output logic [CW-1:0]    run_cnt,
  output logic [EVT_W-1:0] evt_cnt
);

  typedef enum logic [1:0] {
    MODE_BOTH  = 2'b00,
    MODE_ONES  = 2'b01,
    MODE_ZEROS = 2'b10,
    MODE_OFF   = 2'b11
  } mode_e;

  localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);

  // Registered state
  logic             r_last_bit;
  logic [CW-1:0]    r_run_cnt;
  logic [EVT_W-1:0] r_evt_cnt;

  // Combinational helpers
  mode_e            w_mode;
  logic             w_ones_en;
  logic             w_zeros_en;
  logic             w_run_full;
  logic [CW-1:0]    w_run_nxt;
  logic             w_evt_hit;
  logic [EVT_W-1:0] w_evt_nxt;

  assign w_mode     = mode_e'(mode);
  assign w_ones_en  = (w_mode == MODE_BOTH) || (w_mode == MODE_ONES);
  assign w_zeros_en = (w_mode == MODE_BOTH) || (w_mode == MODE_ZEROS);
  assign w_run_full = (r_run_cnt == RUN_MAX);

  // Next run length for an enabled sample.
  always_comb begin
    // NOTE: give every always_comb output a default first so that no path
    // leaves it unassigned, which would infer a latch.
    w_run_nxt = r_run_cnt;
    if ((r_run_cnt == '0) || (x != r_last_bit)) begin
      w_run_nxt = CW'(1);
    end else if (!w_run_full) begin
      w_run_nxt = r_run_cnt + CW'(1);
    end else if (!overlap) begin
      // Non-overlapping: the sample after a full run opens a new block.
      w_run_nxt = CW'(1);
    end
  end

  // An event is the transition into a full run, counted only when the
  // polarity being sampled is enabled by the mode at that edge. A run held
  // full under overlap therefore counts once.
  assign w_evt_hit = en && !w_run_full && (w_run_nxt == RUN_MAX) &&
                     (x ? w_ones_en : w_zeros_en);

  always_comb begin
    w_evt_nxt = r_evt_cnt;
    if (clr_cnt) begin
      w_evt_nxt = '0;
    end else if (w_evt_hit && !(&r_evt_cnt)) begin
      w_evt_nxt = r_evt_cnt + EVT_W'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_bit <= 1'b0;
      r_run_cnt  <= '0;
      r_evt_cnt  <= '0;
    end else begin
      if (en) begin
        r_last_bit <= x;
        r_run_cnt  <= w_run_nxt;
      end
      // clr_cnt acts independently of en; the increment term already
      // requires en.
      r_evt_cnt <= w_evt_nxt;
    end
  end

  // Moore detection decoded from registered state, re-gated by the live mode.
  assign y_ones  = w_run_full &&  r_last_bit && w_ones_en;
  assign y_zeros = w_run_full && !r_last_bit && w_zeros_en;
  assign y       = y_ones || y_zeros;
  assign run_cnt = r_run_cnt;
  assign evt_cnt = r_evt_cnt;

endmodule

// File: tb/tb_run_length_detector.sv
// -----------------------------------------------------------------------------
// tb_run_length_detector
//
// Directed bench for run_length_detector with RUN_LEN=3. Two instances share
// all stimulus: u_dut uses EVT_W=8, u_sat uses EVT_W=2 to exercise counter
// saturation. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_run_length_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       x;
  logic [1:0] mode;
  logic       overlap;
  logic       clr_cnt;

  logic       y, y_ones, y_zeros;
  logic [1:0] run_cnt;
  logic [7:0] evt_cnt;

  logic       s_y, s_y_ones, s_y_zeros;
  logic [1:0] s_run_cnt;
  logic [1:0] s_evt_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_length_detector #(.RUN_LEN(3), .EVT_W(8)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .x       (x),
    .mode    (mode),
    .overlap (overlap),
    .clr_cnt (clr_cnt),
    .y       (y),
    .y_ones  (y_ones),
    .y_zeros (y_zeros),
    .run_cnt (run_cnt),
    .evt_cnt (evt_cnt)
  );

  run_length_detector #(.RUN_LEN(3), .EVT_W(2)) u_sat (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .x       (x),
    .mode    (mode),
    .overlap (overlap),
    .clr_cnt (clr_cnt),
    .y       (s_y),
    .y_ones  (s_y_ones),
    .y_zeros (s_y_zeros),
    .run_cnt (s_run_cnt),
    .evt_cnt (s_evt_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compare every output of the main instance against expected values.
  task automatic check_state(input string tag, input logic exp_yo,
                             input logic exp_yz, input logic [1:0] exp_run,
                             input logic [7:0] exp_evt);
    check({tag, ".y"},       32'(y),       32'(exp_yo | exp_yz));
    check({tag, ".y_ones"},  32'(y_ones),  32'(exp_yo));
    check({tag, ".y_zeros"}, 32'(y_zeros), 32'(exp_yz));
    check({tag, ".run_cnt"}, 32'(run_cnt), 32'(exp_run));
    check({tag, ".evt_cnt"}, 32'(evt_cnt), 32'(exp_evt));
  endtask

  // Apply one clock edge with the given en/x, then settle past the edge.
  task automatic step(input logic e, input logic xv);
    en = e;
    x  = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    en      = 1'b1;
    clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    en      = 1'b0;
    x       = 1'b0;
    mode    = 2'b00;
    overlap = 1'b1;
    clr_cnt = 1'b0;
    #2;

    // Reset state
    do_reset();
    check_state("rst", 0, 0, 0, 0);
    check("rst.sat_evt", 32'(s_evt_cnt), 0);

    // Overlap=1, ones run 1,1,1,1,0
    step(1, 1); check_state("ov1.s1", 0, 0, 1, 0);
    step(1, 1); check_state("ov1.s2", 0, 0, 2, 0);
    step(1, 1); check_state("ov1.s3", 1, 0, 3, 1);
    step(1, 1); check_state("ov1.s4", 1, 0, 3, 1);
    step(1, 0); check_state("ov1.s5", 0, 0, 1, 1);

    // Overlap=0, six zeros
    do_reset();
    overlap = 1'b0;
    step(1, 0); check_state("ov0.s1", 0, 0, 1, 0);
    step(1, 0); check_state("ov0.s2", 0, 0, 2, 0);
    step(1, 0); check_state("ov0.s3", 0, 1, 3, 1);
    step(1, 0); check_state("ov0.s4", 0, 0, 1, 1);
    step(1, 0); check_state("ov0.s5", 0, 0, 2, 1);
    step(1, 0); check_state("ov0.s6", 0, 1, 3, 2);

    // Mode ones-only with zeros run, then re-gate to both
    do_reset();
    overlap = 1'b1;
    mode    = 2'b01;
    step(1, 0); step(1, 0); step(1, 0);
    check_state("m01", 0, 0, 3, 0);
    mode = 2'b00;
    #1;
    check_state("m00.regate", 0, 1, 3, 0);

    // Mode disabled: full run present but no detection, no event
    mode = 2'b11;
    step(1, 1); step(1, 1); step(1, 1);
    check_state("m11", 0, 0, 3, 0);
    mode = 2'b00;

    // Alternating bits
    do_reset();
    step(1, 1); step(1, 0); step(1, 1); step(1, 0);
    check_state("alt.s4", 0, 0, 1, 0);
    step(1, 1);
    check_state("alt.s5", 0, 0, 1, 0);

    // Gaps in en
    do_reset();
    step(1, 1); check_state("gap.s1", 0, 0, 1, 0);
    step(0, 0); check_state("gap.h1", 0, 0, 1, 0);
    step(0, 0); check_state("gap.h2", 0, 0, 1, 0);
    step(1, 1); check_state("gap.s2", 0, 0, 2, 0);
    step(1, 1); check_state("gap.s3", 1, 0, 3, 1);

    // Reset mid-run
    do_reset();
    step(1, 1); step(1, 1);
    do_reset();
    check_state("midrst", 0, 0, 0, 0);
    step(1, 1);
    check_state("midrst.s1", 0, 0, 1, 0);

    // clr_cnt on the detecting edge: clear wins, run tracking unaffected
    step(1, 1);
    clr_cnt = 1'b1;
    step(1, 1);
    clr_cnt = 1'b0;
    check_state("clr", 1, 0, 3, 0);

    // Five separate ones runs: EVT_W=2 instance saturates at 3
    do_reset();
    for (int r = 0; r < 5; r++) begin
      step(1, 1); step(1, 1); step(1, 1); step(1, 0);
    end
    check("sat.evt8", 32'(evt_cnt), 5);
    check("sat.evt2", 32'(s_evt_cnt), 3);
    check("sat.run2", 32'(s_run_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
